// File: rtl/aes_sched_pkg.sv
// Shared widths and the tag-line entry type for the aes_128 request scheduler.
package aes_sched_pkg;

  localparam int BLOCK_W        = 128;
  localparam int AES128_LATENCY = 21;
  // Widest requester ID the tag line can carry; the port ID is truncated from it.
  localparam int ID_W           = 8;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/aes_rsp_fifo.sv
// Synchronous FIFO with extra-bit wrapping pointers; no fall-through, empty read returns zero.
module aes_rsp_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic [AW:0]      o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr, r_rd_ptr;
  logic             w_full, w_pop, w_wr_en;

  assign o_count = r_wr_ptr - r_rd_ptr;
  assign o_empty = (o_count == '0);
  assign w_full  = o_count[AW];
  assign w_pop   = i_pop && !o_empty;
  // A push at full is only accepted alongside a pop, which frees the slot being written.
  assign w_wr_en = i_push && (!w_full || w_pop);
  assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/aes_128_sched.sv
// Round-robin front end for a non-stallable aes_128 pipeline: issue register,
// latency-matched tag line and credit-guarded response FIFO.
module aes_128_sched import aes_sched_pkg::*; #(
  parameter  int NUM_REQ    = 2,
  parameter  int LATENCY    = AES128_LATENCY,
  parameter  int FIFO_DEPTH = 32,
  localparam int RID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [NUM_REQ-1:0]         i_req_valid,
  output logic [NUM_REQ-1:0]         o_req_ready,
  input  logic [NUM_REQ*BLOCK_W-1:0] i_req_state,
  input  logic [NUM_REQ*BLOCK_W-1:0] i_req_key,
  output logic [BLOCK_W-1:0]         o_core_state,
  output logic [BLOCK_W-1:0]         o_core_key,
  input  logic [BLOCK_W-1:0]         i_core_out,
  output logic                       o_rsp_valid,
  input  logic                       i_rsp_ready,
  output logic [BLOCK_W-1:0]         o_rsp_data,
  output logic [RID_W-1:0]           o_rsp_id,
  output logic                       o_idle
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int INF_W = $clog2(LATENCY + 2);
  localparam int FW    = BLOCK_W + ID_W;

  logic [RID_W-1:0]   r_rr_ptr;
  logic [INF_W-1:0]   r_inflight;
  tag_t               r_tag [LATENCY+1];

  logic [BLOCK_W-1:0] w_st  [NUM_REQ];
  logic [BLOCK_W-1:0] w_key [NUM_REQ];
  logic [RID_W-1:0]   w_cand [NUM_REQ];
  logic [RID_W-1:0]   w_gnt;
  logic               w_gnt_vld, w_credit_ok, w_hs, w_push;
  logic [CNT_W-1:0]   w_fifo_count;
  logic               w_fifo_empty;
  logic [FW-1:0]      w_fifo_dout;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    assign w_st[i]   = i_req_state[i*BLOCK_W +: BLOCK_W];
    assign w_key[i]  = i_req_key[i*BLOCK_W +: BLOCK_W];
    assign w_cand[i] = RID_W'((int'(r_rr_ptr) + i) % NUM_REQ);
  end

  // Scan from the far end so the candidate closest to rr_ptr wins.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (i_req_valid[w_cand[k]]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = w_cand[k];
      end
    end
  end

  // Every accepted block already owns a FIFO slot, so pushes never need to stall.
  assign w_credit_ok = (int'(r_inflight) + int'(w_fifo_count)) < FIFO_DEPTH;
  assign w_hs        = i_rst_n && w_gnt_vld && w_credit_ok;
  assign o_req_ready = w_hs ? (NUM_REQ'(1) << w_gnt) : '0;
  assign w_push      = r_tag[LATENCY].valid;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rr_ptr     <= '0;
      o_core_state <= '0;
      o_core_key   <= '0;
    end else if (w_hs) begin
      r_rr_ptr     <= RID_W'((int'(w_gnt) + 1) % NUM_REQ);
      o_core_state <= w_st[w_gnt];
      o_core_key   <= w_key[w_gnt];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i <= LATENCY; i++) r_tag[i] <= '0;
    end else begin
      r_tag[0] <= '{valid: w_hs, id: ID_W'(w_gnt)};
      for (int i = 1; i <= LATENCY; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_inflight <= '0;
    end else begin
      case ({w_hs, w_push})
        2'b10:   r_inflight <= r_inflight + INF_W'(1);
        2'b01:   r_inflight <= r_inflight - INF_W'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  aes_rsp_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_rsp_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_data  ({i_core_out, r_tag[LATENCY].id}),
    .i_pop   (i_rsp_ready),
    .o_data  (w_fifo_dout),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign o_rsp_valid = !w_fifo_empty;
  assign o_rsp_data  = w_fifo_dout[ID_W +: BLOCK_W];
  assign o_rsp_id    = RID_W'(w_fifo_dout[ID_W-1:0]);
  assign o_idle      = (r_inflight == '0) && w_fifo_empty;

endmodule

// File: tb/tb_aes_128_sched.sv
// Directed bench for aes_128_sched with a latency-matched stand-in for the aes_128 core.
module tb_aes_128_sched;

  localparam int L = 21;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   req_valid, req_ready;
  logic [255:0] req_state, req_key;
  logic [127:0] core_state, core_key, core_out, rsp_data;
  logic         rsp_valid, rsp_ready, idle;
  logic [0:0]   rsp_id;

  logic         req_valid1, req_ready1, rsp_valid1, rsp_ready1, idle1;
  logic [127:0] req_state1, req_key1, core_state1, core_key1, core_out1, rsp_data1;
  logic [0:0]   rsp_id1;

  always #5 clk = ~clk;

  aes_128_sched #(.NUM_REQ(2), .LATENCY(L), .FIFO_DEPTH(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_state(req_state), .i_req_key(req_key), .o_core_state(core_state),
    .o_core_key(core_key), .i_core_out(core_out), .o_rsp_valid(rsp_valid),
    .i_rsp_ready(rsp_ready), .o_rsp_data(rsp_data), .o_rsp_id(rsp_id), .o_idle(idle));

  aes_128_sched #(.NUM_REQ(1), .LATENCY(L), .FIFO_DEPTH(32)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid1), .o_req_ready(req_ready1),
    .i_req_state(req_state1), .i_req_key(req_key1), .o_core_state(core_state1),
    .o_core_key(core_key1), .i_core_out(core_out1), .o_rsp_valid(rsp_valid1),
    .i_rsp_ready(rsp_ready1), .o_rsp_data(rsp_data1), .o_rsp_id(rsp_id1), .o_idle(idle1));

  // Stand-in cipher: the real FIPS-197 answer for the known vector, a cheap mix otherwise.
  function automatic logic [127:0] aes_fn(input logic [127:0] s, input logic [127:0] k);
    if (s == FIPS_PT && k == FIPS_KEY) return FIPS_CT;
    return s ^ {k[63:0], k[127:64]};
  endfunction

  logic [127:0] cp0 [L];
  logic [127:0] cp1 [L];
  always @(posedge clk) begin
    cp0[0] <= aes_fn(core_state, core_key);
    cp1[0] <= aes_fn(core_state1, core_key1);
    for (int i = 1; i < L; i++) begin
      cp0[i] <= cp0[i-1];
      cp1[i] <= cp1[i-1];
    end
  end
  assign core_out  = cp0[L-1];
  assign core_out1 = cp1[L-1];

  int n_chk = 0, n_pass = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  typedef struct packed {
    logic [0:0]   id;
    logic [127:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   gnt_q[$];
  int   n_acc = 0, n_pop = 0;
  exp_t mon_e;

  // Scoreboard: sampled mid-cycle, after the bench has driven its inputs for this cycle.
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      check("ready_onehot0", 128'($onehot0(req_ready)), 128'd1);
      for (int i = 0; i < 2; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          exp_q.push_back('{id: 1'(i), data: aes_fn(req_state[i*128 +: 128], req_key[i*128 +: 128])});
          gnt_q.push_back(i);
          n_acc++;
        end
      end
      if (rsp_valid && rsp_ready) begin
        n_pop++;
        if (exp_q.size() == 0) begin
          check("rsp_spurious", 128'(rsp_valid), 128'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("rsp_data", rsp_data, mon_e.data);
          check("rsp_id", 128'(rsp_id), 128'(mon_e.id));
        end
      end
    end
  end

  task automatic wait_idle(input string tag, input int max);
    int n = 0;
    while (!idle && n < max) begin
      @(negedge clk);
      n++;
    end
    check(tag, 128'(idle), 128'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  int e, nv, seq;

  initial begin
    rst_n = 1'b0; req_valid = '0; req_state = '0; req_key = '0; rsp_ready = 1'b0;
    req_valid1 = 1'b0; req_state1 = '0; req_key1 = '0; rsp_ready1 = 1'b0;
    repeat (2) @(negedge clk);
    req_valid = 2'b11;
    #1;
    check("rst_ready", 128'(req_ready), 128'd0);
    check("rst_rsp_valid", 128'(rsp_valid), 128'd0);
    check("rst_rsp_data", rsp_data, 128'd0);
    check("rst_rsp_id", 128'(rsp_id), 128'd0);
    check("rst_idle", 128'(idle), 128'd1);
    check("rst_core_state", core_state, 128'd0);
    check("rst_core_key", core_key, 128'd0);

    @(negedge clk);
    rst_n = 1'b1; req_valid = '0; rsp_ready = 1'b1; rsp_ready1 = 1'b1;

    // FIPS-197 vector from requester 0; the consuming edge is the 23rd after the handshake.
    @(negedge clk);
    req_valid = 2'b01; req_state[127:0] = FIPS_PT; req_key[127:0] = FIPS_KEY;
    #1 check("fips_ready", 128'(req_ready), 128'd1);
    @(negedge clk);
    req_valid = '0;
    e = 1;
    while (!rsp_valid && e < 40) begin
      @(negedge clk);
      e++;
    end
    check("fips_lat", 128'(e), 128'd23);
    check("fips_data", rsp_data, FIPS_CT);
    check("fips_id", 128'(rsp_id), 128'd0);
    @(negedge clk);
    check("fips_idle", 128'(idle), 128'd1);

    // Round-robin: the FIPS grant left the pointer at 1, so grants go 1,0,1,0...
    gnt_q.delete();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      req_valid = 2'b11;
      req_state = {128'(32'hB000_0000 + i), 128'(32'hA000_0000 + i)};
      req_key   = {128'(32'hB100_0000 + i), 128'(32'hA100_0000 + i)};
    end
    @(negedge clk);
    req_valid = '0;
    check("rr_count", 128'(gnt_q.size()), 128'd8);
    for (int i = 0; i < 8 && i < gnt_q.size(); i++)
      check("rr_grant", 128'(gnt_q[i]), 128'((i + 1) % 2));
    e = 0;
    while (!rsp_valid && e < 40) begin
      @(negedge clk);
      e++;
    end
    for (int i = 0; i < 8; i++) begin
      check("rr_nogap", 128'(rsp_valid), 128'd1);
      @(negedge clk);
    end
    check("rr_end", 128'(rsp_valid), 128'd0);
    wait_idle("rr_idle", 40);

    // Backpressure: with no pops exactly 32 blocks get in.
    n_acc = 0; n_pop = 0; seq = 0; rsp_ready = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      req_valid = 2'b01; req_state[127:0] = 128'(32'hC000_0000 + seq); req_key[127:0] = 128'(seq * 7);
      seq++;
    end
    #3;
    check("bp_accepts", 128'(n_acc), 128'd32);
    check("bp_ready_low", 128'(req_ready), 128'd0);
    @(negedge clk);
    rsp_ready = 1'b1; req_state[127:0] = 128'(32'hC000_0000 + seq); seq++;
    #3 check("bp_pop_vld", 128'(rsp_valid), 128'd1);
    @(negedge clk);
    rsp_ready = 1'b0; req_state[127:0] = 128'(32'hC000_0000 + seq); seq++;
    #3;
    check("bp_one_accept", 128'(req_ready), 128'd1);
    check("bp_one_pop", 128'(n_pop), 128'd1);
    @(negedge clk);
    req_state[127:0] = 128'(32'hC000_0000 + seq); seq++;
    #3;
    check("bp_blocked", 128'(req_ready), 128'd0);
    check("bp_accepts2", 128'(n_acc), 128'd33);

    // Full FIFO drained while streaming: one stall cycle, then one accept every cycle.
    @(negedge clk);
    rsp_ready = 1'b1; req_state[127:0] = 128'(32'hC000_0000 + seq); seq++;
    #3 check("ff_first", 128'(req_ready), 128'd0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      req_state[127:0] = 128'(32'hC000_0000 + seq); seq++;
      #3;
      check("ff_ready", 128'(req_ready), 128'd1);
      check("ff_credit", 128'((n_acc - n_pop) <= 32), 128'd1);
    end
    e = 0;
    while (n_acc < 100 && e < 400) begin
      @(negedge clk);
      req_state[127:0] = 128'(32'hC000_0000 + seq); seq++;
      #3 e++;
    end
    @(negedge clk);
    req_valid = '0;
    wait_idle("bp_drain", 200);
    check("bp_total_acc", 128'(n_acc), 128'd100);
    check("bp_total_pop", 128'(n_pop), 128'd100);
    check("bp_sb_empty", 128'(exp_q.size()), 128'd0);

    // Reset with 10 blocks in flight: none of them may come out.
    n_acc = 0;
    e = 0;
    while (n_acc < 10 && e < 100) begin
      @(negedge clk);
      req_valid = 2'b01; req_state[127:0] = 128'(32'hD000_0000 + seq); seq++;
      #3 e++;
    end
    @(negedge clk);
    req_valid = '0; rst_n = 1'b0; rsp_ready = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1; rsp_ready = 1'b1;
    #1 check("rst_mid_idle", 128'(idle), 128'd1);
    nv = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid) nv++;
    end
    check("rst_mid_no_rsp", 128'(nv), 128'd0);

    // Single-requester build runs the same FIPS vector.
    @(negedge clk);
    req_valid1 = 1'b1; req_state1 = FIPS_PT; req_key1 = FIPS_KEY;
    #1 check("one_ready", 128'(req_ready1), 128'd1);
    @(negedge clk);
    req_valid1 = 1'b0;
    e = 1;
    while (!rsp_valid1 && e < 40) begin
      @(negedge clk);
      e++;
    end
    check("one_lat", 128'(e), 128'd23);
    check("one_data", rsp_data1, FIPS_CT);
    check("one_id", 128'(rsp_id1), 128'd0);
    @(negedge clk);
    check("one_idle", 128'(idle1), 128'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
